apb_master_bridge: RTL and testbench

//  Single-outstanding APB master sitting directly upstream of the APB slave.
//  - Accepts one command on a valid/ready request port.
//  - Runs exactly one APB SETUP->ACCESS transfer per command.
//  - Returns read data and error status on a valid/ready response port.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_req_hold.sv | 50 +++++
 rtl/apb_master_bridge.sv | 147 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - state encoding and shared widths for the APB master bridge
package apb_pkg;

  localparam int APB_ADDR_W = 2;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10,
    RESP   = 2'b11
  } apb_state_t;

endpackage

// File: rtl/apb_req_hold.sv
// rtl/apb_req_hold.sv - command holding register feeding the APB address/data phase
module apb_req_hold
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
) (
  input  logic              p_clk,
  input  logic              p_reset_n,
  input  logic              load,
  input  logic              in_write,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              hold_write,
  output logic [ADDR_W-1:0] hold_addr,
  output logic [DATA_W-1:0] hold_wdata
);

  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  always_comb begin
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (load) begin
      write_d = in_write;
      addr_d  = in_addr;
      wdata_d = in_wdata;
    end
  end

  always_ff @(posedge p_clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign hold_write = write_q;
  assign hold_addr  = addr_q;
  assign hold_wdata = wdata_q;

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding APB master; define APB_MASTER_TIMEOUT_EN
// to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
`ifdef APB_MASTER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic              p_clk,
  input  logic              p_reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              p_sel,
  output logic              p_enable,
  output logic              p_write,
  output logic [ADDR_W-1:0] p_addr,
  output logic [DATA_W-1:0] p_w_data,
  input  logic              p_ready,
  input  logic              p_slv_err,
  input  logic [DATA_W-1:0] p_r_data
);

  apb_state_t        state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              p_sel_q, p_sel_d;
  logic              p_enable_q, p_enable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              load;
  logic              hold_write;
  logic              timed_out;

  // cmd_ready_q is only high in IDLE, so it doubles as the accept qualifier.
  assign load = cmd_valid & cmd_ready_q;

  apb_req_hold #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_hold (
    .p_clk      (p_clk),
    .p_reset_n  (p_reset_n),
    .load       (load),
    .in_write   (cmd_write),
    .in_addr    (cmd_addr),
    .in_wdata   (cmd_wdata),
    .hold_write (hold_write),
    .hold_addr  (p_addr),
    .hold_wdata (p_w_data)
  );

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP) begin
      cnt_d = '0;
    end else if (state_q == ACCESS && !p_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign timed_out = (state_q == ACCESS) && !p_ready && (cnt_d == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge p_clk or negedge p_reset_n) begin
    if (!p_reset_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE:   if (load) state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (p_ready) begin
          state_d       = RESP;
          rsp_rdata_d   = hold_write ? '0 : p_r_data;
          rsp_err_d     = p_slv_err;
          rsp_timeout_d = 1'b0;
        end else if (timed_out) begin
          state_d       = RESP;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end
      end
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with state_q.
    cmd_ready_d = (state_d == IDLE);
    p_sel_d     = (state_d == SETUP) || (state_d == ACCESS);
    p_enable_d  = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge p_clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      p_sel_q       <= 1'b0;
      p_enable_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      p_sel_q       <= p_sel_d;
      p_enable_q    <= p_enable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign p_sel       = p_sel_q;
  assign p_enable    = p_enable_q;
  assign p_write     = hold_write;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - randomized bench for apb_master_bridge with an array-backed slave model
module tb_apb_master_bridge;

  logic        p_clk = 1'b0;
  logic        p_reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [1:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        p_sel;
  logic        p_enable;
  logic        p_write;
  logic [1:0]  p_addr;
  logic [31:0] p_w_data;
  logic        p_ready = 1'b0;
  logic        p_slv_err = 1'b0;
  logic [31:0] p_r_data = '0;

  always #5 p_clk = ~p_clk;

  apb_master_bridge dut (
    .p_clk       (p_clk),
    .p_reset_n   (p_reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .p_sel       (p_sel),
    .p_enable    (p_enable),
    .p_write     (p_write),
    .p_addr      (p_addr),
    .p_w_data    (p_w_data),
    .p_ready     (p_ready),
    .p_slv_err   (p_slv_err),
    .p_r_data    (p_r_data)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mem [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Entered and left at a negedge with the bridge idle; checks every cycle of one command.
  task automatic run_txn(input logic wr, input logic [1:0] addr, input logic [31:0] wdata,
                         input int waits, input logic err, input int stall);
    logic [31:0] exp_rdata;
    check("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    @(negedge p_clk);
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_write = ~wr;
    cmd_addr  = addr + 2'd1;
    cmd_wdata = $urandom;
    check("setup_sel_en", {p_sel, p_enable}, 2'b10);
    check("setup_write", p_write, wr);
    check("setup_addr", p_addr, addr);
    check("setup_wdata", p_w_data, wdata);
    check("setup_cmd_ready", cmd_ready, 0);
    p_ready = 1'($urandom_range(0, 1));
    for (int i = 0; i <= waits; i++) begin
      @(negedge p_clk);
      check("access_sel_en", {p_sel, p_enable}, 2'b11);
      check("access_write", p_write, wr);
      check("access_addr", p_addr, addr);
      check("access_wdata", p_w_data, wdata);
      check("access_cmd_ready", cmd_ready, 0);
      if (i < waits) begin
        p_ready   = 1'b0;
        p_slv_err = 1'($urandom_range(0, 1));
        p_r_data  = $urandom;
      end else begin
        p_ready   = 1'b1;
        p_slv_err = err;
        p_r_data  = wr ? $urandom : mem[addr];
      end
    end
    exp_rdata = wr ? 32'h0 : mem[addr];
    if (wr && !err) mem[addr] = wdata;
    for (int i = 0; i <= stall; i++) begin
      @(negedge p_clk);
      p_ready   = 1'($urandom_range(0, 1));
      p_slv_err = 1'($urandom_range(0, 1));
      p_r_data  = $urandom;
      check("resp_valid", rsp_valid, 1);
      check("resp_rdata", rsp_rdata, exp_rdata);
      check("resp_err", rsp_err, err);
      check("resp_timeout", rsp_timeout, 0);
      check("resp_sel_en", {p_sel, p_enable}, 2'b00);
      check("resp_cmd_ready", cmd_ready, 0);
      check("resp_addr_hold", p_addr, addr);
      rsp_ready = (i == stall);
    end
    @(negedge p_clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    p_ready   = 1'b0;
    check("done_rsp_valid", rsp_valid, 0);
    check("done_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = $urandom;

    repeat (2) @(negedge p_clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_sel_en", {p_sel, p_enable}, 2'b00);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_addr", p_addr, 0);
    check("rst_wdata", p_w_data, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    p_reset_n = 1'b1;
    @(negedge p_clk);

    run_txn(1'b1, 2'd0, 32'hDEADBEEF, 0, 1'b0, 0);
    run_txn(1'b1, 2'd2, 32'h0000_1234, 0, 1'b0, 0);
    run_txn(1'b0, 2'd2, 32'h0, 0, 1'b0, 0);
    check("readback_model", mem[2], 32'h0000_1234);
    run_txn(1'b0, 2'd1, 32'h0, 2, 1'b1, 0);
    run_txn(1'b0, 2'd0, 32'h0, 1, 1'b0, 5);

    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
              int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)));
    end

    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 2'd3;
    @(negedge p_clk);
    cmd_valid = 1'b0;
    p_ready   = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      @(negedge p_clk);
      check("to_access_wait", {p_sel, p_enable}, 2'b11);
      p_r_data = $urandom;
    end
    @(negedge p_clk);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_timeout", rsp_timeout, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
`else
    for (int i = 0; i < 30; i++) begin
      @(negedge p_clk);
      check("nto_access_wait", {p_sel, p_enable}, 2'b11);
    end
    p_ready  = 1'b1;
    p_r_data = mem[3];
    @(negedge p_clk);
    p_ready = 1'b0;
    check("nto_rsp_valid", rsp_valid, 1);
    check("nto_rsp_rdata", rsp_rdata, mem[3]);
    check("nto_rsp_timeout", rsp_timeout, 0);
`endif
    rsp_ready = 1'b1;
    @(negedge p_clk);
    rsp_ready = 1'b0;
    check("after_wait_cmd_ready", cmd_ready, 1);

    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 2'd1;
    cmd_wdata = 32'hA5A5_0001;
    @(negedge p_clk);
    cmd_valid = 1'b0;
    @(negedge p_clk);
    check("pre_rst_access", {p_sel, p_enable}, 2'b11);
    #1 p_reset_n = 1'b0;
    #1;
    check("mid_rst_sel_en", {p_sel, p_enable}, 2'b00);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    p_ready = 1'b1;
    rsp_ready = 1'b1;
    @(negedge p_clk);
    p_reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge p_clk);
      check("post_rst_rsp_valid", rsp_valid, 0);
      check("post_rst_sel", p_sel, 0);
      check("post_rst_cmd_ready", cmd_ready, 1);
    end
    p_ready = 1'b0;
    rsp_ready = 1'b0;
    run_txn(1'b0, 2'd2, 32'h0, 0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
